// File: rtl/pipe_decode_ctrl_if.sv
// pipe_decode_ctrl_if: ID-stage instruction fields in, hazard status and ID/EX controls out.
// Latency: none, this is a plain bundle of nets.
// Backpressure: stall_out travels back to the fetch/decode side on this bundle.
// master: the pipeline front end. It drives the ID fields and flush, and observes stall and the EX controls.
// slave : pipe_decode_ctrl.
interface pipe_decode_ctrl_if;
  logic       id_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       flush;

  logic       stall_out;
  logic       mdu_busy;
  logic       ex_valid;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic       ex_mem_write;
  logic       ex_illegal;
  logic [1:0] ex_mem_to_reg;
  logic [1:0] ex_pc_src;
  logic [3:0] ex_alu_op;
  logic [2:0] ex_branch_type;
  logic [4:0] ex_dst;

  modport master (
    output id_valid, opcode, funct, rs, rt, rd, flush,
    input  stall_out, mdu_busy, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_illegal, ex_mem_to_reg, ex_pc_src, ex_alu_op, ex_branch_type, ex_dst
  );

  modport slave (
    input  id_valid, opcode, funct, rs, rt, rd, flush,
    output stall_out, mdu_busy, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_illegal, ex_mem_to_reg, ex_pc_src, ex_alu_op, ex_branch_type, ex_dst
  );
endinterface

// File: rtl/pipe_decode_ctrl.sv
// pipe_decode_ctrl: MIPS-style ID decode with load-use/MDU hazard control feeding the ID/EX register.
// Latency: ex_* follow the ID fields one cycle later. stall_out is combinational in the same cycle.
// Backpressure: stall_out holds PC and IF/ID and a bubble enters EX. flush kills the EX entry and never stalls.
// Ports: clk, reset (async active-high, clears all state); id_ex (slave) carries id_valid, opcode, funct,
//        rs, rt, rd and flush in, and stall_out, mdu_busy and the registered ex_* controls out.
module pipe_decode_ctrl #(
  parameter int MDU_EN     = 1,
  parameter int MDU_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_decode_ctrl_if.slave id_ex
);
  localparam logic [5:0] OP_RTYPE  = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23, OP_SW     = 6'h2B;
  localparam logic [5:0] FN_JR     = 6'h08, FN_JALR   = 6'h09, FN_MFHI  = 6'h10, FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT   = 6'h18, FN_MULTU  = 6'h19, FN_DIV   = 6'h1A, FN_DIVU = 6'h1B;
  localparam logic [5:0] MDU_LOAD  = 6'(MDU_CYCLES);
  localparam logic       MDU_ON    = (MDU_EN != 0);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic [2:0] branch_type;
    logic [4:0] dst;
  } ctrl_t;

  ctrl_t      ex_q, ex_d, dec;
  logic [5:0] cnt_q, cnt_d;

  logic       legal, wr_en, mem_rd, mem_wr, mdu_op, mdu_start;
  logic [4:0] wr_dst;
  logic [1:0] m2r, pc_src;
  logic [2:0] alu_lo, br_type;
  logic       rt_src, load_use, mdu_haz, stall, issue;

  // Instruction classification. MDU ops fall through as illegal when the unit is not built.
  always_comb begin
    legal     = 1'b0;
    wr_en     = 1'b0;
    wr_dst    = id_ex.rt;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mdu_op    = 1'b0;
    mdu_start = 1'b0;
    m2r       = 2'b00;
    pc_src    = 2'b00;
    case (id_ex.opcode)
      OP_RTYPE: begin
        wr_dst = id_ex.rd;
        case (id_ex.funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            legal = 1'b1;
            wr_en = 1'b1;
          end
          FN_JR: begin
            legal  = 1'b1;
            pc_src = 2'b11;
          end
          FN_JALR: begin
            legal  = 1'b1;
            wr_en  = 1'b1;
            m2r    = 2'b11;
            pc_src = 2'b11;
          end
          FN_MFHI, FN_MFLO: begin
            legal  = MDU_ON;
            mdu_op = MDU_ON;
            wr_en  = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            legal     = MDU_ON;
            mdu_op    = MDU_ON;
            mdu_start = MDU_ON;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        legal = 1'b1;
        wr_en = 1'b1;
      end
      OP_LW: begin
        legal  = 1'b1;
        wr_en  = 1'b1;
        mem_rd = 1'b1;
        m2r    = 2'b01;
      end
      OP_SW: begin
        legal  = 1'b1;
        mem_wr = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: legal = 1'b1;
      OP_J: begin
        legal  = 1'b1;
        pc_src = 2'b01;
      end
      OP_JAL: begin
        legal  = 1'b1;
        wr_en  = 1'b1;
        wr_dst = 5'd31;
        m2r    = 2'b11;
        pc_src = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_lo  = 3'b000;
    br_type = 3'b000;
    case (id_ex.opcode)
      OP_RTYPE:          alu_lo = 3'b010;
      OP_BEQ:            alu_lo = 3'b001;
      OP_ANDI:           alu_lo = 3'b100;
      OP_ORI:            alu_lo = 3'b011;
      OP_XORI:           alu_lo = 3'b110;
      OP_SLTI, OP_SLTIU: alu_lo = 3'b101;
      default:           alu_lo = 3'b000;
    endcase
    case (id_ex.opcode)
      OP_BNE:    br_type = 3'b001;
      OP_BLEZ:   br_type = 3'b010;
      OP_BGTZ:   br_type = 3'b011;
      OP_REGIMM: br_type = 3'b100;
      default:   br_type = 3'b000;
    endcase
  end

  // Non-writing instructions carry dst 0, so reg_write can never be set toward $0.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    if (legal) begin
      dec.reg_write   = wr_en & (wr_dst != 5'd0);
      dec.mem_read    = mem_rd;
      dec.mem_write   = mem_wr;
      dec.mem_to_reg  = m2r;
      dec.pc_src      = pc_src;
      dec.alu_op      = {id_ex.opcode[0], alu_lo};
      dec.branch_type = br_type;
      dec.dst         = wr_en ? wr_dst : 5'd0;
    end else begin
      dec.illegal = 1'b1;
    end
  end

  // rt is a source operand only for R-type, beq/bne and sw.
  assign rt_src = (id_ex.opcode == OP_RTYPE) || (id_ex.opcode == OP_BEQ) ||
                  (id_ex.opcode == OP_BNE)   || (id_ex.opcode == OP_SW);

  assign load_use = ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                    ((ex_q.dst == id_ex.rs) || (rt_src && (ex_q.dst == id_ex.rt)));
  assign mdu_haz  = mdu_op && (cnt_q != 6'd0);

  // flush outranks every hazard: the EX entry dies anyway, so holding IF/ID would only lose a cycle.
  assign stall = id_ex.id_valid && !id_ex.flush && (load_use || mdu_haz);
  assign issue = id_ex.id_valid && !id_ex.flush && !stall;

  always_comb begin
    ex_d = issue ? dec : '0;
    if (issue && mdu_start) begin
      cnt_d = MDU_LOAD;
    end else if (cnt_q != 6'd0) begin
      cnt_d = cnt_q - 6'd1;
    end else begin
      cnt_d = 6'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= 6'd0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign id_ex.stall_out      = stall;
  assign id_ex.mdu_busy       = (cnt_q != 6'd0);
  assign id_ex.ex_valid       = ex_q.valid;
  assign id_ex.ex_reg_write   = ex_q.reg_write;
  assign id_ex.ex_mem_read    = ex_q.mem_read;
  assign id_ex.ex_mem_write   = ex_q.mem_write;
  assign id_ex.ex_illegal     = ex_q.illegal;
  assign id_ex.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign id_ex.ex_pc_src      = ex_q.pc_src;
  assign id_ex.ex_alu_op      = ex_q.alu_op;
  assign id_ex.ex_branch_type = ex_q.branch_type;
  assign id_ex.ex_dst         = ex_q.dst;
endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// tb_pipe_decode_ctrl: drives two decoders (MDU built / not built) with directed and random ID traffic.
// Latency: model predicts the ex_* values one cycle after the ID fields and stall_out in the same cycle.
// Backpressure: stalled instructions are held at the ID inputs until they issue or are flushed.
module tb_pipe_decode_ctrl;
  localparam int CYC = 4;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic [2:0] branch_type;
    logic [4:0] dst;
  } ex_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic       id_valid = 1'b0, flush = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;

  int n_pass = 0;
  int n_total = 0;

  pipe_decode_ctrl_if bus0 ();
  pipe_decode_ctrl_if bus1 ();

  assign bus0.id_valid = id_valid; assign bus0.flush = flush;
  assign bus0.opcode = opcode; assign bus0.funct = funct;
  assign bus0.rs = rs; assign bus0.rt = rt; assign bus0.rd = rd;
  assign bus1.id_valid = id_valid; assign bus1.flush = flush;
  assign bus1.opcode = opcode; assign bus1.funct = funct;
  assign bus1.rs = rs; assign bus1.rt = rt; assign bus1.rd = rd;

  pipe_decode_ctrl #(.MDU_EN(1), .MDU_CYCLES(CYC)) dut0 (.clk(clk), .reset(reset), .id_ex(bus0.slave));
  pipe_decode_ctrl #(.MDU_EN(0), .MDU_CYCLES(CYC)) dut1 (.clk(clk), .reset(reset), .id_ex(bus1.slave));

  always #5 clk = ~clk;

  ex_t dut_ex0, dut_ex1;
  assign dut_ex0 = {bus0.ex_valid, bus0.ex_reg_write, bus0.ex_mem_read, bus0.ex_mem_write, bus0.ex_illegal,
                    bus0.ex_mem_to_reg, bus0.ex_pc_src, bus0.ex_alu_op, bus0.ex_branch_type, bus0.ex_dst};
  assign dut_ex1 = {bus1.ex_valid, bus1.ex_reg_write, bus1.ex_mem_read, bus1.ex_mem_write, bus1.ex_illegal,
                    bus1.ex_mem_to_reg, bus1.ex_pc_src, bus1.ex_alu_op, bus1.ex_branch_type, bus1.ex_dst};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  ex_t m_ex [2] = '{default: '0};
  int  m_cnt[2] = '{default: 0};

  function automatic void ref_decode(input bit mdu_en, input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] t, input logic [4:0] d, output ex_t e,
                                     output bit mdu_op, output bit starts, output bit rt_src);
    bit legal = 0;
    bit writes = 0;
    logic [4:0] tgt = t;
    logic [2:0] alu = 3'b000;
    logic [2:0] br = 3'b000;
    e = '0;
    mdu_op = 0;
    starts = 0;
    rt_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    if (op == 6'h00) begin
      tgt = d;
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
        legal = 1; writes = 1;
      end else if (fn == 6'h08) begin
        legal = 1; e.pc_src = 2'b11;
      end else if (fn == 6'h09) begin
        legal = 1; writes = 1; e.pc_src = 2'b11; e.mem_to_reg = 2'b11;
      end else if (fn inside {6'h10, 6'h12}) begin
        legal = mdu_en; mdu_op = mdu_en; writes = 1;
      end else if (fn inside {[6'h18:6'h1B]}) begin
        legal = mdu_en; mdu_op = mdu_en; starts = mdu_en;
      end
    end else if (op inside {[6'h08:6'h0F]}) begin
      legal = 1; writes = 1;
    end else if (op == 6'h23) begin
      legal = 1; writes = 1; e.mem_read = 1; e.mem_to_reg = 2'b01;
    end else if (op == 6'h2B) begin
      legal = 1; e.mem_write = 1;
    end else if (op inside {[6'h04:6'h07]}) begin
      legal = 1; br = 3'(op - 6'h04);
    end else if (op == 6'h01) begin
      legal = 1; br = 3'd4;
    end else if (op == 6'h02) begin
      legal = 1; e.pc_src = 2'b01;
    end else if (op == 6'h03) begin
      legal = 1; writes = 1; tgt = 5'd31; e.pc_src = 2'b01; e.mem_to_reg = 2'b11;
    end
    if (op == 6'h00) alu = 3'b010;
    else if (op == 6'h04) alu = 3'b001;
    else if (op == 6'h0C) alu = 3'b100;
    else if (op == 6'h0D) alu = 3'b011;
    else if (op == 6'h0E) alu = 3'b110;
    else if (op == 6'h0A || op == 6'h0B) alu = 3'b101;
    if (legal) begin
      e.valid = 1;
      e.alu_op = {op[0], alu};
      e.branch_type = br;
      if (writes) begin
        e.dst = tgt;
        e.reg_write = (tgt != 0);
      end
    end else begin
      e = '0;
      e.valid = 1;
      e.illegal = 1;
    end
  endfunction

  function automatic void ref_eval(input int k, output bit stall, output ex_t nxt, output int cnt_nxt);
    ex_t d;
    bit mdu_op, starts, rt_src, lu, bubble;
    ref_decode(k == 0, opcode, funct, rt, rd, d, mdu_op, starts, rt_src);
    lu = m_ex[k].valid && m_ex[k].mem_read && m_ex[k].reg_write &&
         (m_ex[k].dst == rs || (rt_src && m_ex[k].dst == rt));
    stall = id_valid && !flush && (lu || (mdu_op && m_cnt[k] > 0));
    bubble = flush || !id_valid || stall;
    nxt = bubble ? '0 : d;
    cnt_nxt = (!bubble && starts) ? CYC : ((m_cnt[k] > 0) ? m_cnt[k] - 1 : 0);
  endfunction

  always @(posedge clk or posedge reset) begin : model_upd
    ex_t nx0, nx1;
    bit s0, s1;
    int c0, c1;
    if (reset) begin
      m_ex[0] <= '0; m_ex[1] <= '0;
      m_cnt[0] <= 0; m_cnt[1] <= 0;
    end else begin
      ref_eval(0, s0, nx0, c0);
      ref_eval(1, s1, nx1, c1);
      m_ex[0] <= nx0; m_ex[1] <= nx1;
      m_cnt[0] <= c0; m_cnt[1] <= c1;
    end
  end

  always @(negedge clk) begin : compare
    ex_t e;
    bit s;
    int c;
    ref_eval(0, s, e, c);
    chk("stall0", 32'(bus0.stall_out), 32'(s));
    chk("ex0", 32'(dut_ex0), 32'(m_ex[0]));
    chk("busy0", 32'(bus0.mdu_busy), 32'(m_cnt[0] != 0));
    ref_eval(1, s, e, c);
    chk("stall1", 32'(bus1.stall_out), 32'(s));
    chk("ex1", 32'(dut_ex1), 32'(m_ex[1]));
    chk("busy1", 32'(bus1.mdu_busy), 32'(m_cnt[1] != 0));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    id_valid = 1'b1; flush = 1'b0;
    opcode = op; funct = fn; rs = s; rt = t; rd = d;
  endtask

  task automatic idle();
    id_valid = 1'b0; flush = 1'b0;
    opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0;
  endtask

  task automatic rand_ins();
    logic [5:0] op, fn;
    fn = 6'($urandom_range(0, 63));
    case ($urandom_range(0, 20))
      0:  begin op = 6'h00; fn = 6'h20; end
      1:  begin op = 6'h00; fn = 6'h2A; end
      2, 3: op = 6'h23;
      4:  op = 6'h2B;
      5:  op = 6'h04;
      6:  op = 6'h05;
      7:  op = 6'h08;
      8:  op = 6'h0D;
      9:  begin op = 6'h00; fn = 6'h18; end
      10: begin op = 6'h00; fn = 6'h1A; end
      11: begin op = 6'h00; fn = 6'h12; end
      12: begin op = 6'h00; fn = 6'h10; end
      13: op = 6'h03;
      14: begin op = 6'h00; fn = 6'h09; end
      15: begin op = 6'h00; fn = 6'h08; end
      16: op = 6'h01;
      17: op = 6'h07;
      18: op = 6'h0E;
      19: op = 6'h0A;
      default: op = 6'($urandom_range(0, 63));
    endcase
    set_ins(op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    id_valid = ($urandom_range(0, 99) < 85);
  endtask

  int  stalls, busyc;
  ex_t r_e;
  bit  r_st;
  int  r_cn;

  initial begin
    #3;
    chk("reset_ex0", 32'(dut_ex0), 32'h0);
    chk("reset_busy0", 32'(bus0.mdu_busy), 32'h0);
    chk("reset_stall0", 32'(bus0.stall_out), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // lw $8 then add $9,$8,$1: one stall, one bubble
    set_ins(6'h23, 6'h00, 5'd1, 5'd8, 5'd0);
    step();
    chk("lw_ex_mem_read", 32'(bus0.ex_mem_read), 32'h1);
    chk("lw_ex_m2r", 32'(bus0.ex_mem_to_reg), 32'h1);
    set_ins(6'h00, 6'h20, 5'd8, 5'd1, 5'd9);
    #1 chk("lu_stall", 32'(bus0.stall_out), 32'h1);
    step();
    chk("lu_bubble_valid", 32'(bus0.ex_valid), 32'h0);
    chk("lu_stall_clear", 32'(bus0.stall_out), 32'h0);
    step();
    chk("add_dst", 32'(bus0.ex_dst), 32'd9);
    chk("add_alu", 32'(bus0.ex_alu_op), 32'b0010);
    chk("add_rw", 32'(bus0.ex_reg_write), 32'h1);

    // mult then mflo: four stalled cycles
    set_ins(6'h00, 6'h18, 5'd2, 5'd3, 5'd0);
    step();
    chk("mult_busy", 32'(bus0.mdu_busy), 32'h1);
    chk("nomdu_mult_illegal", 32'(bus1.ex_illegal), 32'h1);
    chk("nomdu_mult_valid", 32'(bus1.ex_valid), 32'h1);
    chk("nomdu_busy", 32'(bus1.mdu_busy), 32'h0);
    set_ins(6'h00, 6'h12, 5'd0, 5'd0, 5'd4);
    stalls = 0;
    busyc = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus0.mdu_busy) busyc++;
      if (!bus0.stall_out) break;
      stalls++;
      step();
    end
    chk("mflo_stall_cycles", 32'(stalls), 32'd4);
    chk("mdu_busy_cycles", 32'(busyc), 32'd4);
    step();
    chk("mflo_dst", 32'(bus0.ex_dst), 32'd4);
    chk("mflo_valid", 32'(bus0.ex_valid), 32'h1);

    // flush while div sits in ID
    set_ins(6'h00, 6'h1A, 5'd1, 5'd2, 5'd0);
    flush = 1'b1;
    #1 chk("flush_stall", 32'(bus0.stall_out), 32'h0);
    step();
    chk("flush_bubble", 32'(dut_ex0), 32'h0);
    chk("flush_no_busy", 32'(bus0.mdu_busy), 32'h0);

    // addi to $0, then an unknown opcode
    set_ins(6'h08, 6'h00, 5'd3, 5'd0, 5'd0);
    step();
    chk("addi0_valid", 32'(bus0.ex_valid), 32'h1);
    chk("addi0_rw", 32'(bus0.ex_reg_write), 32'h0);
    set_ins(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0);
    step();
    chk("ill_flag", 32'(bus0.ex_illegal), 32'h1);
    chk("ill_valid", 32'(bus0.ex_valid), 32'h1);
    idle();
    step();
    chk("ill_one_cycle", 32'(bus0.ex_illegal), 32'h0);

    // jal, then reset pulse in the middle of a mult
    set_ins(6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
    step();
    chk("jal_dst", 32'(bus0.ex_dst), 32'd31);
    chk("jal_m2r", 32'(bus0.ex_mem_to_reg), 32'b11);
    chk("jal_pc", 32'(bus0.ex_pc_src), 32'b01);
    set_ins(6'h00, 6'h19, 5'd1, 5'd2, 5'd0);
    step();
    chk("multu_busy", 32'(bus0.mdu_busy), 32'h1);
    set_ins(6'h00, 6'h12, 5'd0, 5'd0, 5'd7);
    #1 reset = 1'b1;
    #1;
    chk("arst_ex", 32'(dut_ex0), 32'h0);
    chk("arst_busy", 32'(bus0.mdu_busy), 32'h0);
    #1 reset = 1'b0;
    #2 chk("post_rst_no_stall", 32'(bus0.stall_out), 32'h0);
    step();
    chk("post_rst_mflo_dst", 32'(bus0.ex_dst), 32'd7);

    // randomized traffic; stalled instructions are held as a real IF/ID would
    idle();
    for (int c = 0; c < 3000; c++) begin
      ref_eval(0, r_st, r_e, r_cn);
      if (!r_st) rand_ins();
      flush = ($urandom_range(0, 9) == 0);
      step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
